// File: rtl/uart_rx_core_if.sv
// Receive-byte stream from the UART RX core toward the register block.
// master = byte producer (uart_rx_core), slave = consumer.
interface uart_rx_core_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_core.sv
// UART receive core: 2-flop RX synchronizer, 16x baud tick oversampling,
// start/data/[parity]/stop deframing, small receive FIFO on a valid/ready port.
// Optional feature macro: UART_RX_PARITY_EN (parity state and checker built;
// without it parity_en/parity_odd are ignored and parity_err stays 0).
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                RX,
  input  logic [DIV_W-1:0]    baud_div,
  input  logic                parity_en,
  input  logic                parity_odd,
  uart_rx_core_if.master      rxq,
  output logic                frame_err,
  output logic                parity_err,
  output logic                overrun,
  output logic                busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic                 rx_m, rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic                 tick;
  logic [TW-1:0]        tcnt, tcnt_n;
  logic [BW-1:0]        bcnt, bcnt_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic                 start_det, stop_done, half_due, bit_due;
  logic                 push_req, push_ok, pop, full, empty;
  logic [AW:0]          wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
  logic                 par_bad, par_bad_n;
`else
  logic                 unused_par;
  assign unused_par = parity_en ^ parity_odd;
`endif

  // Two-flop synchronizer for the asynchronous RX pin; idles high.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // Baud tick down-counter; reloaded on start detect so ticks align to the start edge.
  always_ff @(posedge PCLK) begin
    if (PRESET)                div_cnt <= '0;
    else if (start_det || tick) div_cnt <= baud_div;
    else                       div_cnt <= div_cnt - 1'b1;
  end
  assign tick = (div_cnt == '0);

  assign half_due = tick && (tcnt == TW'(OVERSAMPLE/2 - 1));
  assign bit_due  = tick && (tcnt == TW'(OVERSAMPLE - 1));
  assign busy     = (state != IDLE);

  // FSM and deframing datapath registers.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state   <= IDLE;
      tcnt    <= '0;
      bcnt    <= '0;
      shreg   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      tcnt    <= tcnt_n;
      bcnt    <= bcnt_n;
      shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bad <= par_bad_n;
`endif
    end
  end

  // Next-state logic: tcnt counts ticks within a bit, bcnt counts data bits.
  always_comb begin
    state_n   = state;
    tcnt_n    = tcnt;
    bcnt_n    = bcnt;
    shreg_n   = shreg;
    start_det = 1'b0;
    stop_done = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n = par_bad;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n   = START;
          tcnt_n    = '0;
          start_det = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_bad_n = 1'b0;
`endif
        end
      end
      START: begin
        if (half_due) begin
          // A start bit that is high again at mid-bit was a glitch.
          tcnt_n  = '0;
          bcnt_n  = '0;
          state_n = rx_s ? IDLE : DATA;
        end else if (tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_due) begin
          tcnt_n  = '0;
          shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
          bcnt_n  = bcnt + 1'b1;
          if (bcnt == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_n = parity_en ? PARITY : STOP;
`else
            state_n = STOP;
`endif
          end
        end else if (tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_due) begin
          tcnt_n    = '0;
          par_bad_n = rx_s ^ (^shreg) ^ parity_odd;
          state_n   = STOP;
        end else if (tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
`endif
      STOP: begin
        // Leave at mid-stop so a following start edge is not missed.
        if (bit_due) begin
          tcnt_n    = '0;
          stop_done = 1'b1;
          state_n   = IDLE;
        end else if (tick) begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO control: a pop frees a slot on the same edge, so push-while-full succeeds with a pop.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = rxq.rx_valid && rxq.rx_ready;
`ifdef UART_RX_PARITY_EN
  assign push_req = stop_done && rx_s && !par_bad;
`else
  assign push_req = stop_done && rx_s;
`endif
  assign push_ok  = push_req && (!full || pop);

  assign rxq.rx_valid = !empty;
  assign rxq.rx_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge PCLK) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  // FIFO pointers and one-cycle status pulses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      frame_err  <= stop_done && !rx_s;
`ifdef UART_RX_PARITY_EN
      parity_err <= stop_done && par_bad;
`else
      parity_err <= 1'b0;
`endif
      overrun    <= push_req && full && !pop;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed scenarios plus randomized
// frames, checked against a frame-level reference model (byte queue + flag counts).
module tb_uart_rx_core;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        RX = 1'b1;
  logic [15:0] baud_div = '0;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic        frame_err, parity_err, overrun, busy;

  uart_rx_core_if #(.DATA_BITS(8)) rxq ();

  uart_rx_core #(
    .DATA_BITS(8), .OVERSAMPLE(16), .FIFO_DEPTH(4), .DIV_W(16)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .RX(RX), .baud_div(baud_div),
    .parity_en(parity_en), .parity_odd(parity_odd), .rxq(rxq),
    .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun), .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // observed side
  int         fe_cnt = 0, pe_cnt = 0, ov_cnt = 0;
  int         rise_cyc = -1, fall_cyc = -1;
  logic       v_q = 1'b0, b_q = 1'b0;
  logic [7:0] got[$];
  int         pop_cyc[$];

  // reference model
  logic [7:0] mq[$];
  int         m_fe = 0, m_pe = 0, m_ov = 0;

  // monitor on the falling edge, away from the active edge
  always @(negedge PCLK) begin
    if (frame_err)  fe_cnt++;
    if (parity_err) pe_cnt++;
    if (overrun)    ov_cnt++;
    if (rxq.rx_valid && rxq.rx_ready) begin
      got.push_back(rxq.rx_data);
      pop_cyc.push_back(cyc);
    end
    if (rxq.rx_valid && !v_q) rise_cyc = cyc;
    if (!busy && b_q) fall_cyc = cyc;
    v_q = rxq.rx_valid;
    b_q = busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // frame-level behaviour: stop=0 -> frame error, parity mismatch -> parity error,
  // clean byte -> queued if room else overrun (no pops while frames arrive)
  task automatic model_frame(input logic [7:0] d, input logic use_par, input logic par,
                             input logic stp);
    logic fe, pe;
    fe = !stp;
    pe = use_par && (par != ((^d) ^ parity_odd));
    if (fe) m_fe++;
    if (pe) m_pe++;
    if (!fe && !pe) begin
      if (mq.size() < 4) mq.push_back(d);
      else m_ov++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic use_par, input logic par,
                            input logic stp, input int gap_bits);
    int bp;
    bp = (int'(baud_div) + 1) * 16;
    RX = 1'b0;
    step(bp);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      step(bp);
    end
    if (use_par) begin
      RX = par;
      step(bp);
    end
    RX = stp;
    step(bp);
    RX = 1'b1;
    model_frame(d, use_par, par, stp);
    if (gap_bits > 0) step(gap_bits * bp);
  endtask

  task automatic drain(input string tag);
    got.delete();
    pop_cyc.delete();
    rxq.rx_ready = 1'b1;
    for (int i = 0; i < 16 && rxq.rx_valid; i++) step(1);
    rxq.rx_ready = 1'b0;
    chk({tag, "_empty"}, rxq.rx_valid, 0);
    chk({tag, "_count"}, got.size(), mq.size());
    for (int i = 0; i < got.size() && i < mq.size(); i++)
      chk({tag, "_byte"}, got[i], mq[i]);
    mq.delete();
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_frame_err"},  fe_cnt, m_fe);
    chk({tag, "_parity_err"}, pe_cnt, m_pe);
    chk({tag, "_overrun"},    ov_cnt, m_ov);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_chk, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int         e_edge;
    logic [7:0] d;
    logic       up, par, stp;

    rxq.rx_ready = 1'b0;
    step(4);
    chk("rst_valid", rxq.rx_valid, 0);
    chk("rst_data",  rxq.rx_data, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_fe",    frame_err, 0);
    chk("rst_pe",    parity_err, 0);
    chk("rst_ov",    overrun, 0);
    PRESET = 1'b0;
    step(4);

    // 8N1 0xA5 at full rate: push at D+152 with D = E+2
    baud_div = 16'd0;
    e_edge = cyc + 1;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 2);
    chk("a5_latency",   rise_cyc - e_edge, 154);
    chk("a5_busy_fall", fall_cyc, rise_cyc);
    chk("a5_data",      rxq.rx_data, 8'hA5);
    chk_flags("a5");
    drain("a5");

    // one-cycle low glitch: START at D=E+2, rejected at D+8
    e_edge = cyc + 1;
    RX = 1'b0;
    step(1);
    RX = 1'b1;
    step(9);
    chk("glitch_busy_mid", busy, 1);
    step(1);
    chk("glitch_busy_end", busy, 0);
    step(40);
    chk("glitch_valid", rxq.rx_valid, 0);
    chk_flags("glitch");

    // stop bit forced low
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 3);
    chk("ferr_valid", rxq.rx_valid, 0);
    chk("ferr_busy",  busy, 0);
    chk_flags("ferr");

`ifdef UART_RX_PARITY_EN
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 2);
    chk("par_bad_valid", rxq.rx_valid, 0);
    chk_flags("par_bad");
    send_frame(8'h07, 1'b1, 1'b1, 1'b1, 2);
    chk("par_ok_data", rxq.rx_data, 8'h07);
    drain("par_ok");
    parity_en = 1'b0;
`endif

    // five back-to-back bytes into a four-entry FIFO
    for (int i = 1; i <= 5; i++)
      send_frame(8'(i), 1'b0, 1'b0, 1'b1, (i == 5) ? 2 : 0);
    chk("ovr_head", rxq.rx_data, 8'h01);
    chk_flags("ovr");
    drain("ovr");
    chk("ovr_pop_n", pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) chk("ovr_pop_span", pop_cyc[3] - pop_cyc[0], 3);

    // reset in the middle of DATA at baud_div=3, with a byte already queued
    baud_div = 16'd3;
    send_frame(8'h11, 1'b0, 1'b0, 1'b1, 2);
    chk("rst_pre_valid", rxq.rx_valid, 1);
    RX = 1'b0;
    step(64);
    RX = 1'b1;
    step(64);
    RX = 1'b0;
    step(64);
    RX = 1'b1;
    step(64);
    chk("rst_mid_busy_pre", busy, 1);
    PRESET = 1'b1;
    step(1);
    chk("rstm_valid", rxq.rx_valid, 0);
    chk("rstm_data",  rxq.rx_data, 0);
    chk("rstm_busy",  busy, 0);
    chk("rstm_fe",    frame_err, 0);
    chk("rstm_pe",    parity_err, 0);
    chk("rstm_ov",    overrun, 0);
    PRESET = 1'b0;
    mq.delete();
    step(128);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 2);
    drain("post_rst");
    chk_flags("post_rst");

    // randomized frames
    for (int n = 0; n < 24; n++) begin
      baud_div = 16'($urandom_range(0, 2));
`ifdef UART_RX_PARITY_EN
      parity_en  = 1'($urandom_range(0, 1));
      parity_odd = 1'($urandom_range(0, 1));
      up = parity_en;
`else
      up = 1'b0;
`endif
      d   = 8'($urandom);
      stp = ($urandom_range(0, 4) != 0);
      par = (^d) ^ parity_odd ^ ($urandom_range(0, 3) == 0);
      send_frame(d, up, par, stp, 1 + int'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0 || n == 23) drain("rnd");
    end
    chk_flags("final");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
